// File: rtl/lp4_pwrup_seq_if.sv
// Timer and ZQ-command handshake bundle between the LPDDR4 power-up sequencer
// and its downstream level_delay timer / command path.
interface lp4_pwrup_seq_if;
  logic        tmr_en;
  logic [15:0] tmr_dly;
  logic        tmr_done;
  logic        zq_req;
  logic        zq_ack;

  modport master (
    output tmr_en,
    output tmr_dly,
    output zq_req,
    input  tmr_done,
    input  zq_ack
  );

  modport slave (
    input  tmr_en,
    input  tmr_dly,
    input  zq_req,
    output tmr_done,
    output zq_ack
  );
endinterface

// File: rtl/lp4_pwrup_seq.sv
// LPDDR4 power-up/init sequencer driving a level_delay timer.
// Define LP4_PWRUP_ZQ_EN to include the ZQ calibration request/wait steps.
//
// state      | meaning
// S_IDLE     | waiting for start, DRAM held in reset
// S_RST_HOLD | RESET_n low for T_INIT1
// S_CKE_WAIT | RESET_n high, CKE low for T_INIT3
// S_CKE_SET  | CKE high for T_INIT5
// S_ZQ_REQ   | ZQ-start requested, waiting for zq_ack
// S_ZQ_WAIT  | ZQ calibration/latency wait for T_ZQCAL
// S_DONE     | DRAM ready for commands
module lp4_pwrup_seq #(
  parameter logic [15:0] T_INIT1 = 16'd200,
  parameter logic [15:0] T_INIT3 = 16'd2000,
  parameter logic [15:0] T_INIT5 = 16'd20,
  parameter logic [15:0] T_ZQCAL = 16'd1000
) (
  input  logic        clk_core,
  input  logic        rst_core_n,
  input  logic        start,
  input  logic        abort,
  lp4_pwrup_seq_if.master bus,
  output logic        dram_reset_n,
  output logic        dram_cke,
  output logic        init_busy,
  output logic        init_done,
  output logic [2:0]  step
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_HOLD = 3'd1,
    S_CKE_WAIT = 3'd2,
    S_CKE_SET  = 3'd3,
    S_ZQ_REQ   = 3'd4,
    S_ZQ_WAIT  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic        arm, arm_nxt;
  logic        tmr_en_q;
  logic [15:0] tmr_dly_q;

  function automatic logic is_timed(input state_t s);
    return (s == S_RST_HOLD) || (s == S_CKE_WAIT) || (s == S_CKE_SET) || (s == S_ZQ_WAIT);
  endfunction

  function automatic logic [15:0] t_of(input state_t s);
    case (s)
      S_RST_HOLD: return T_INIT1;
      S_CKE_WAIT: return T_INIT3;
      S_CKE_SET:  return T_INIT5;
`ifdef LP4_PWRUP_ZQ_EN
      S_ZQ_WAIT:  return T_ZQCAL;
`endif
      default:    return 16'd0;
    endcase
  endfunction

  function automatic state_t after_timed(input state_t s);
    case (s)
      S_RST_HOLD: return S_CKE_WAIT;
      S_CKE_WAIT: return S_CKE_SET;
`ifdef LP4_PWRUP_ZQ_EN
      S_CKE_SET:  return S_ZQ_REQ;
`else
      S_CKE_SET:  return S_DONE;
`endif
      default:    return S_DONE;
    endcase
  endfunction

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state <= S_IDLE;
      arm   <= 1'b0;
    end else begin
      state <= state_nxt;
      arm   <= arm_nxt;
    end
  end

  // arm marks the first cycle of a timed state; tmr_done is not trusted then
  always_comb begin
    state_nxt = state;
    arm_nxt   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_RST_HOLD;
          arm_nxt   = 1'b1;
        end
      end
      S_RST_HOLD, S_CKE_WAIT, S_CKE_SET, S_ZQ_WAIT: begin
        if (!arm && bus.tmr_done) begin
          state_nxt = after_timed(state);
          arm_nxt   = is_timed(state_nxt);
        end
      end
      S_ZQ_REQ: begin
`ifdef LP4_PWRUP_ZQ_EN
        if (bus.zq_ack) begin
          state_nxt = S_ZQ_WAIT;
          arm_nxt   = 1'b1;
        end
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      arm_nxt   = 1'b0;
    end
  end

  // Outputs are registered from the next state so the DRAM pins never glitch
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      tmr_en_q     <= 1'b0;
      tmr_dly_q    <= 16'd0;
      dram_reset_n <= 1'b0;
      dram_cke     <= 1'b0;
      init_busy    <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      tmr_en_q <= is_timed(state_nxt) && !arm_nxt;
      if (arm_nxt) begin
        tmr_dly_q <= t_of(state_nxt);
      end else if (state_nxt == S_IDLE) begin
        tmr_dly_q <= 16'd0;
      end
      dram_reset_n <= (state_nxt != S_IDLE) && (state_nxt != S_RST_HOLD);
      dram_cke     <= (state_nxt == S_CKE_SET) || (state_nxt == S_ZQ_REQ) ||
                      (state_nxt == S_ZQ_WAIT) || (state_nxt == S_DONE);
      init_busy    <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      init_done    <= (state_nxt == S_DONE);
    end
  end

`ifdef LP4_PWRUP_ZQ_EN
  logic zq_req_q;

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      zq_req_q <= 1'b0;
    end else begin
      zq_req_q <= (state_nxt == S_ZQ_REQ);
    end
  end

  assign bus.zq_req = zq_req_q;
`else
  logic [16:0] unused_zq;
  assign unused_zq  = {bus.zq_ack, T_ZQCAL};
  assign bus.zq_req = 1'b0;
`endif

  assign bus.tmr_en  = tmr_en_q;
  assign bus.tmr_dly = tmr_dly_q;
  assign step        = state;

endmodule
